// File: rtl/fifo_drain_controller_pkg.sv
// Shared definitions for the fifo drain controller and other fifo consumers.
package fifo_drain_controller_pkg;

  // Fixed BRAM read latency seen by every consumer of the capture fifo.
  localparam int READ_LATENCY_DEFAULT = 3;

  // Drain sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_controller_skid.sv
// Small register-based FIFO that absorbs fifo read returns until the
// downstream accepts them. The caller guarantees no push when full and no
// pop when empty.
module drain_skid_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/fifo_drain_controller.sv
// Drains a commanded number of words from the BRAM fifo onto a ready/valid
// stream, hiding the read latency with credit-limited issue into a skid buffer.
module fifo_drain_controller
  import fifo_drain_controller_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     length,
  output logic                       busy,
  output logic                       done,
  input  logic [WIDTH-1:0]           fifo_out,
  input  logic                       fifo_empty,
  output logic                       fifo_out_req,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int AW         = $clog2(DEPTH);
  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int CW         = $clog2(SKID_DEPTH + 1);

  drain_state_t          r_state;
  drain_state_t          w_state_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [AW:0]           r_remaining;
  logic [CW-1:0]         r_in_flight;
  logic [READ_LATENCY-1:0] r_tag;

  logic                  w_issue;
  logic                  w_return;
  logic                  w_pop;
  logic                  w_skid_empty;
  logic [CW-1:0]         w_skid_count;
  logic [WIDTH-1:0]      w_skid_head;
  logic [CW:0]           w_credit_used;

  assign w_return = r_tag[READ_LATENCY-1];
  assign w_pop    = !w_skid_empty && m_ready;

  // A slot being popped this cycle is already free for a new request, so the
  // loop sustains one word per cycle while the buffer still cannot overflow.
  assign w_credit_used = (CW+1)'(r_in_flight) + (CW+1)'(w_skid_count) - (CW+1)'(w_pop);

  assign w_issue = !rst && (r_state == ST_RUN) && (r_remaining != '0) && !fifo_empty &&
                   (w_credit_used < (CW+1)'(SKID_DEPTH));

  // Next-state and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) w_state_nxt = ST_RUN;
          else              w_done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_issue && (r_remaining == (AW+1)'(1))) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((r_in_flight == '0) && (w_skid_count == CW'(1)) && w_pop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Words still to request; loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if ((r_state == ST_IDLE) && start && (length != '0)) begin
      r_remaining <= length;
    end else if (w_issue) begin
      r_remaining <= r_remaining - (AW+1)'(1);
    end
  end

  // Requests issued whose data has not yet returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_flight <= '0;
    end else begin
      case ({w_issue, w_return})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  // Tag delay line marking the cycle each request's data appears on fifo_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  drain_skid_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH),
    .CW    (CW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (w_return),
    .push_data (fifo_out),
    .pop       (w_pop),
    .head      (w_skid_head),
    .count     (w_skid_count),
    .empty     (w_skid_empty)
  );

  assign fifo_out_req = w_issue;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign m_valid      = !w_skid_empty;
  assign m_data       = m_valid ? w_skid_head : '0;

endmodule
